// File: rtl/pipe_stage_reg_pkg.sv
//------------------------------------------------------------------------------
// pipe_stage_reg_pkg : shared state encoding and payload defaults for stages
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package pipe_stage_reg_pkg;

   typedef enum logic [1:0] {
      PIPE_ST_EMPTY = 2'b00,
      PIPE_ST_BUSY  = 2'b01,
      PIPE_ST_FULL  = 2'b10
   } pipe_state_e;

   localparam int unsigned PIPE_DATA_W = 32*3 + 5*3 + 32;
   localparam int unsigned PIPE_CTRL_W = 16;

   // NOP control encoding: every enable (jump, dmem, csr_we, uart) is low.
   localparam logic [PIPE_CTRL_W-1:0] PIPE_CTRL_BUBBLE = '0;

endpackage

`default_nettype wire

// File: rtl/pipe_stage_reg_skid_ctrl.sv
//------------------------------------------------------------------------------
// pipe_skid_ctrl : valid/ready control for one elastic stage (skid or single)
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pipe_skid_ctrl
   import pipe_stage_reg_pkg::*;
#(
   parameter int SKID = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic in_valid,
   input  logic out_ready,
   input  logic flush,
   output logic load_main,
   output logic load_skid,
   output logic move_skid,
   output logic out_valid,
   output logic in_ready
);

   generate
      if (SKID != 0) begin : g_skid
         pipe_state_e state;
         pipe_state_e state_next;
         logic        acc;
         logic        fire;

         // Both handshake outputs decode only the state register.
         assign out_valid = (state != PIPE_ST_EMPTY);
         assign in_ready  = (state != PIPE_ST_FULL);
         assign acc       = in_valid & in_ready & ~flush;
         assign fire      = out_valid & out_ready;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               state <= PIPE_ST_EMPTY;
            end else begin
               state <= state_next;
            end
         end

         always_comb begin
            state_next = state;
            load_main  = 1'b0;
            load_skid  = 1'b0;
            move_skid  = 1'b0;
            case (state)
               PIPE_ST_EMPTY: begin
                  if (acc) begin
                     load_main  = 1'b1;
                     state_next = PIPE_ST_BUSY;
                  end
               end
               PIPE_ST_BUSY: begin
                  if (acc && fire) begin
                     load_main = 1'b1;
                  end else if (acc) begin
                     load_skid  = 1'b1;
                     state_next = PIPE_ST_FULL;
                  end else if (fire) begin
                     state_next = PIPE_ST_EMPTY;
                  end
               end
               PIPE_ST_FULL: begin
                  if (fire) begin
                     move_skid  = 1'b1;
                     state_next = PIPE_ST_BUSY;
                  end
               end
               default: state_next = PIPE_ST_EMPTY;
            endcase
            // acc already excludes flush; only the skid move needs suppressing.
            if (flush) begin
               move_skid  = 1'b0;
               state_next = PIPE_ST_EMPTY;
            end
         end
      end else begin : g_single
         logic valid;
         logic acc;
         logic fire;

         assign out_valid = valid;
         assign in_ready  = ~valid | out_ready;
         assign acc       = in_valid & in_ready & ~flush;
         assign fire      = valid & out_ready;
         assign load_main = acc;
         assign load_skid = 1'b0;
         assign move_skid = 1'b0;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               valid <= 1'b0;
            end else if (flush) begin
               valid <= 1'b0;
            end else if (acc) begin
               valid <= 1'b1;
            end else if (fire) begin
               valid <= 1'b0;
            end
         end
      end
   endgenerate

endmodule

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
//------------------------------------------------------------------------------
// pipe_stage_reg : elastic pipeline register with bubble ctrl and stall counter
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pipe_stage_reg
   import pipe_stage_reg_pkg::*;
#(
   parameter int                DATA_W      = PIPE_DATA_W,
   parameter int                CTRL_W      = PIPE_CTRL_W,
   parameter logic [CTRL_W-1:0] CTRL_BUBBLE = PIPE_CTRL_BUBBLE,
   parameter int                SKID        = 1,
   parameter int                CNT_W       = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   input  logic              flush,
   output logic [CNT_W-1:0]  stall_cnt
);

   logic              load_main;
   logic              load_skid;
   logic              move_skid;
   logic [DATA_W-1:0] main_data;
   logic [CTRL_W-1:0] main_ctrl;
   logic [DATA_W-1:0] main_src_data;
   logic [CTRL_W-1:0] main_src_ctrl;

   pipe_skid_ctrl #(
      .SKID (SKID)
   ) u_ctrl (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .out_ready (out_ready),
      .flush     (flush),
      .load_main (load_main),
      .load_skid (load_skid),
      .move_skid (move_skid),
      .out_valid (out_valid),
      .in_ready  (in_ready)
   );

   generate
      if (SKID != 0) begin : g_skid_regs
         logic [DATA_W-1:0] skid_data;
         logic [CTRL_W-1:0] skid_ctrl;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               skid_data <= '0;
               skid_ctrl <= '0;
            end else if (load_skid) begin
               skid_data <= in_data;
               skid_ctrl <= in_ctrl;
            end
         end

         assign main_src_data = move_skid ? skid_data : in_data;
         assign main_src_ctrl = move_skid ? skid_ctrl : in_ctrl;
      end else begin : g_no_skid_regs
         assign main_src_data = in_data;
         assign main_src_ctrl = in_ctrl;
      end
   endgenerate

   // Payload registers are deliberately left untouched by flush.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_data <= '0;
         main_ctrl <= '0;
      end else if (load_main || move_skid) begin
         main_data <= main_src_data;
         main_ctrl <= main_src_ctrl;
      end
   end

   assign out_data = main_data;
   assign out_ctrl = out_valid ? main_ctrl : CTRL_BUBBLE;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (out_valid && !out_ready && !(&stall_cnt)) begin
         stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

endmodule

`default_nettype wire
